// File: rtl/joy_db15_responder_if.sv
// Host-side DB15 joystick link pins: shift clock, parallel-load strobe, serial data.
// Latency: none, this is a plain bundle of wires.
// Backpressure: none; the host drives clk/load freely and the device answers on data.
interface joy_db15_responder_if;
    logic joy_clk_in;
    logic joy_load_in;
    logic joy_data_out;

    // Host (reader) side drives the strobes and samples data.
    modport master (
        output joy_clk_in,
        output joy_load_in,
        input  joy_data_out
    );

    // Device (responder) side samples the strobes and drives data.
    modport slave (
        input  joy_clk_in,
        input  joy_load_in,
        output joy_data_out
    );
endinterface

// File: rtl/joy_db15_responder.sv
// Emulates a two-joystick 74HC165 chain: parallel-load {joy1,joy2}, shift MSB-first on host clk rises.
// Latency: host pin edge to joy_data_out change is about 2 sync + FILT_LEN filter + 2 register clks.
// Backpressure: none; host strobes are obeyed as they arrive, clocks past the frame end read 1s.
module joy_db15_responder #(
    parameter int FILT_LEN   = 2,
    parameter int FRAME_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [15:0]          joy1,
    input  logic [15:0]          joy2,
    joy_db15_responder_if.slave  host,
    output logic                 frame_done,
    output logic                 short_frame,
    output logic [5:0]           bit_cnt,
    output logic [15:0]          frame_cnt
);
    localparam logic [5:0] FB6      = 6'(FRAME_BITS);
    // Pin index 0 is the shift clock (idles low), index 1 is load (idles high).
    localparam logic [1:0] PIN_IDLE = 2'b10;

    logic [1:0] sync1_q, sync2_q;
    logic [1:0] filt;
    logic [1:0] prev_q;
    logic       clk_rise, load_fall;

    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  done_q, done_d;
    logic                  short_q, short_d;
    logic                  data_q, data_d;

    // Two-flop synchroniser for both asynchronous host pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= PIN_IDLE;
            sync2_q <= PIN_IDLE;
        end else begin
            sync1_q <= {host.joy_load_in, host.joy_clk_in};
            sync2_q <= sync1_q;
        end
    end

    generate
        if (FILT_LEN == 0) begin : g_nofilt
            assign filt = sync2_q;
        end else begin : g_filt
            localparam int CW = $clog2(FILT_LEN + 1);
            logic [1:0]    filt_q, filt_d;
            logic [CW-1:0] cnt_q [2];
            logic [CW-1:0] cnt_d [2];

            // A new level is accepted only after FILT_LEN consecutive disagreeing samples.
            always_comb begin
                filt_d = filt_q;
                for (int p = 0; p < 2; p++) begin
                    cnt_d[p] = '0;
                    if (sync2_q[p] != filt_q[p]) begin
                        if (cnt_q[p] == CW'(FILT_LEN - 1)) begin
                            filt_d[p] = sync2_q[p];
                        end else begin
                            cnt_d[p] = cnt_q[p] + CW'(1);
                        end
                    end
                end
            end

            // Filter state registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    filt_q <= PIN_IDLE;
                    cnt_q  <= '{default: '0};
                end else begin
                    filt_q <= filt_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign filt = filt_q;
        end
    endgenerate

    // Previous filtered levels for single-cycle edge strobes.
    always_ff @(posedge clk) begin
        if (reset) prev_q <= PIN_IDLE;
        else       prev_q <= filt;
    end

    assign clk_rise  =  filt[0] & ~prev_q[0];
    assign load_fall = ~filt[1] &  prev_q[1];

    // Load/shift next-state: load level dominates, so a coincident clk rise is ignored.
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        short_d     = 1'b0;
        data_d      = (enable && bit_cnt_q < FB6) ? ~shreg_q[FRAME_BITS-1] : 1'b1;
        if (!filt[1]) begin
            shreg_d   = FRAME_BITS'({joy1, joy2});
            bit_cnt_d = '0;
            short_d   = enable && load_fall && (bit_cnt_q != 6'd0) && (bit_cnt_q < FB6);
        end else if (clk_rise && bit_cnt_q < FB6) begin
            shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (enable && bit_cnt_q == FB6 - 6'd1) begin
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q     <= '0;
            bit_cnt_q   <= FB6;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            data_q      <= 1'b1;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            short_q     <= short_d;
            data_q      <= data_d;
        end
    end

    assign host.joy_data_out = data_q;
    assign frame_done        = done_q;
    assign short_frame       = short_q;
    assign bit_cnt           = bit_cnt_q;
    assign frame_cnt         = frame_cnt_q;
endmodule
